// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared constants for the MMIO byte-stream output block: default register
// addresses and the bit layout of the status word.
package mmio_pkg;

  localparam logic [31:0] OUT_ADDR_DEFAULT  = 32'h0000_1000;
  localparam logic [31:0] STAT_ADDR_DEFAULT = 32'h0000_1004;

  localparam int EMPTY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int OVF_BIT   = 2;
  localparam int CNT_LSB   = 8;
  localparam int CNT_MSB   = 15;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
// Synchronous byte FIFO with power-of-two depth. A push while full is only
// accepted when a pop happens on the same edge. No bypass: a byte written into
// an empty FIFO becomes visible on dout the following cycle.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset (pointers and count)
//   push, din   write strobe and byte
//   pop         read strobe (ignored while empty)
//   dout        current head byte (don't-care while empty)
//   count       occupancy, 0..DEPTH
//   full, empty occupancy flags
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_stream_out.sv
// mmio_stream_out
// Sits between a single-cycle core and its data RAM. Two addresses are
// intercepted: OUT_ADDR pushes a byte into an output FIFO feeding a
// valid/ready byte stream, STAT_ADDR reads status and clears the sticky
// overflow flag. Every other access passes straight through to the RAM.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   writeram, ramaddress,
//   writeramdata, readramdata     core data-memory interface
//   ram_we, ram_addr, ram_wdata,
//   ram_rdata                     data RAM interface
//   out_valid, out_data,
//   out_ready                     byte stream output
module mmio_stream_out
  import mmio_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] OUT_ADDR  = WIDTH'(OUT_ADDR_DEFAULT),
  parameter logic [WIDTH-1:0] STAT_ADDR = WIDTH'(STAT_ADDR_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             writeram,
  input  logic [WIDTH-1:0] ramaddress,
  input  logic [WIDTH-1:0] writeramdata,
  output logic [WIDTH-1:0] readramdata,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel_out;
  logic          sel_stat;
  logic          sel_ram;
  logic          push;
  logic          pop;
  logic          ovf_clr;
  logic          ovf_set;
  logic          overflow;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [WIDTH-1:0] status;

  assign sel_out  = (ramaddress == OUT_ADDR);
  assign sel_stat = (ramaddress == STAT_ADDR);
  assign sel_ram  = !sel_out && !sel_stat;

  assign ram_addr  = ramaddress;
  assign ram_wdata = writeramdata;
  assign ram_we    = writeram && sel_ram;

  assign push    = writeram && sel_out;
  assign pop     = out_valid && out_ready;
  assign ovf_clr = writeram && sel_stat && writeramdata[0];
  assign ovf_set = push && full && !pop;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writeramdata[7:0]),
    .dout  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;

  // Set has priority so a drop in the same cycle as a clear is not lost.
  always_ff @(posedge clock) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  always_comb begin
    status                   = '0;
    status[EMPTY_BIT]        = empty;
    status[FULL_BIT]         = full;
    status[OVF_BIT]          = overflow;
    status[CNT_MSB:CNT_LSB]  = 8'(count);
  end

  // Zero-latency load path: the core has no stall.
  always_comb begin
    if (sel_stat)     readramdata = status;
    else if (sel_out) readramdata = '0;
    else              readramdata = ram_rdata;
  end

endmodule

// File: tb/tb_mmio_stream_out.sv
module tb_mmio_stream_out;

  localparam int          DEPTH = 16;
  localparam logic [31:0] OUTA  = 32'h0000_1000;
  localparam logic [31:0] STATA = 32'h0000_1004;

  logic        clock = 1'b0;
  logic        reset;
  logic        writeram;
  logic [31:0] ramaddress;
  logic [31:0] writeramdata;
  logic [31:0] readramdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO as a plain queue plus a sticky flag.
  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] popped[$];

  mmio_stream_out #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .writeram     (writeram),
    .ramaddress   (ramaddress),
    .writeramdata (writeramdata),
    .readramdata  (readramdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    int n;
    n = q.size();
    return (32'(n) << 8) | (32'(m_ovf) << 2) | (32'(n == DEPTH) << 1) | 32'(n == 0);
  endfunction

  // One bus cycle: drive, check combinational outputs against the model,
  // clock it, then advance the model.
  task automatic cyc(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic rdy);
    logic        m_pop;
    logic        m_push;
    logic        m_set;
    logic        m_clr;
    logic [31:0] exp_rd;
    writeram     = wr;
    ramaddress   = addr;
    writeramdata = data;
    out_ready    = rdy;
    ram_rdata    = $urandom();
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    if (addr == OUTA)       exp_rd = 32'h0;
    else if (addr == STATA) exp_rd = stat_exp();
    else                    exp_rd = ram_rdata;
    chk("readramdata", readramdata, exp_rd);
    chk("ram_we", 32'(ram_we), 32'(wr && addr != OUTA && addr != STATA));
    chk("ram_addr", ram_addr, addr);
    chk("ram_wdata", ram_wdata, data);
    @(posedge clock);
    m_pop  = rdy && (q.size() != 0);
    m_push = wr && (addr == OUTA);
    m_clr  = wr && (addr == STATA) && data[0];
    m_set  = m_push && (q.size() == DEPTH) && !m_pop;
    if (m_pop) popped.push_back(q.pop_front());
    if (m_push && !m_set) q.push_back(data[7:0]);
    if (m_set) m_ovf = 1'b1;
    else if (m_clr) m_ovf = 1'b0;
    #1;
  endtask

  task automatic reset_pulse(input logic with_push);
    reset        = 1'b1;
    writeram     = with_push;
    ramaddress   = OUTA;
    writeramdata = 32'h77;
    out_ready    = 1'b0;
    @(posedge clock);
    q.delete();
    m_ovf = 1'b0;
    #1;
    reset    = 1'b0;
    writeram = 1'b0;
  endtask

  initial begin
    int pushed;
    int guard;
    logic [7:0] next_b;
    logic [7:0] sent[$];

    reset = 1'b1; writeram = 1'b0; ramaddress = '0; writeramdata = '0;
    ram_rdata = '0; out_ready = 1'b0;
    m_ovf = 1'b0;
    @(posedge clock);
    reset_pulse(1'b0);

    // Reset state
    #1;
    ramaddress = STATA;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_status", readramdata, 32'h0000_0001);
    @(posedge clock); #1;

    // RAM pass-through
    cyc(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b0, 32'h40, 32'h0, 1'b0);

    // Latency and order
    cyc(1'b1, OUTA, 32'h11, 1'b0);
    chk("first_valid", 32'(out_valid), 32'h1);
    cyc(1'b1, OUTA, 32'h22, 1'b0);
    cyc(1'b1, OUTA, 32'h33, 1'b0);
    ramaddress = STATA; #1;
    chk("stat_3", readramdata, 32'h0000_0300);
    popped.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, STATA, 32'h0, 1'b1);
    chk("order_n", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("order_0", 32'(popped[0]), 32'h11);
      chk("order_1", 32'(popped[1]), 32'h22);
      chk("order_2", 32'(popped[2]), 32'h33);
    end
    ramaddress = STATA; #1;
    chk("stat_empty", readramdata, 32'h0000_0001);

    // Full and overflow
    for (int i = 0; i < 17; i++) cyc(1'b1, OUTA, 32'h50 + 32'(i), 1'b0);
    ramaddress = STATA; #1;
    chk("stat_ovf", readramdata, 32'h0000_1006);
    cyc(1'b1, STATA, 32'h1, 1'b0);
    ramaddress = STATA; #1;
    chk("stat_clr", readramdata, 32'h0000_1002);

    // Full with simultaneous push and pop
    popped.delete();
    cyc(1'b1, OUTA, 32'hAA, 1'b1);
    ramaddress = STATA; #1;
    chk("stat_pp_full", readramdata, 32'h0000_1002);
    for (int i = 0; i < 16; i++) cyc(1'b0, STATA, 32'h0, 1'b1);
    chk("pp_count", 32'(popped.size()), 32'd17);
    if (popped.size() == 17) chk("pp_last", 32'(popped[16]), 32'hAA);
    ramaddress = STATA; #1;
    chk("pp_drained", readramdata, 32'h0000_0001);

    // Wrap-around with random readiness, interleaved with RAM traffic
    popped.delete();
    pushed = 0;
    guard  = 0;
    next_b = 8'h01;
    while (pushed < 40 && guard < 2000) begin
      guard++;
      if (q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        sent.push_back(next_b);
        cyc(1'b1, OUTA, {24'($urandom()), next_b}, 1'($urandom_range(0, 1)));
        next_b++;
        pushed++;
      end else begin
        cyc(1'($urandom_range(0, 1)), {16'h0, 16'($urandom()) & 16'h0FFC},
            $urandom(), 1'($urandom_range(0, 1)));
      end
    end
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      guard++;
      cyc(1'b0, STATA, 32'h0, 1'b1);
    end
    chk("wrap_pushed", 32'(pushed), 32'd40);
    chk("wrap_n", 32'(popped.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < popped.size(); i++)
      chk("wrap_byte", 32'(popped[i]), 32'(sent[i]));
    ramaddress = STATA; #1;
    chk("wrap_status", readramdata, 32'h0000_0001);

    // Reset mid-stream together with a push
    for (int i = 0; i < 5; i++) cyc(1'b1, OUTA, 32'hC0 + 32'(i), 1'b0);
    reset_pulse(1'b1);
    ramaddress = STATA; #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_status", readramdata, 32'h0000_0001);
    @(posedge clock); #1;
    cyc(1'b0, STATA, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_stream_out.md
MMIO_STREAM_OUT -- requirements
Module: mmio_stream_out

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data bus width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the byte FIFO depth; it is a power of two between 2 and 128.
REQ-003 The block SHALL have parameter OUT_ADDR, default 32'h0000_1000, meaning the byte-push register address.
REQ-004 The block SHALL have parameter STAT_ADDR, default 32'h0000_1004, meaning the status/control register address.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset; one clock, and reset is synchronous and active-high.
REQ-007 The block SHALL have port writeram, input, 1 bit: core store strobe.
REQ-008 The block SHALL have port ramaddress, input, WIDTH bits: core data address.
REQ-009 The block SHALL have port writeramdata, input, WIDTH bits: core store data.
REQ-010 The block SHALL have port readramdata, output, WIDTH bits: load data returned to the core.
REQ-011 The block SHALL have port ram_we, output, 1 bit: data RAM write enable.
REQ-012 The block SHALL have ports ram_addr and ram_wdata, outputs, WIDTH bits each: data RAM address and write data.
REQ-013 The block SHALL have port ram_rdata, input, WIDTH bits: data RAM read data.
REQ-014 The block SHALL have port out_valid, output, 1 bit: JPEG byte available.
REQ-015 The block SHALL have port out_data, output, 8 bits: JPEG byte.
REQ-016 The block SHALL have port out_ready, input, 1 bit: downstream accepts the byte.

Function
REQ-017 The block SHALL decode ramaddress combinationally: OUT_ADDR or STAT_ADDR selects MMIO; any other address selects RAM.
REQ-018 ram_addr and ram_wdata SHALL pass ramaddress and writeramdata through unchanged; ram_we SHALL equal writeram and RAM-select.
REQ-019 readramdata SHALL be combinational with zero latency, because the core is single-cycle and has no stall: ram_rdata for RAM-select, the status word for STAT_ADDR, and zero for OUT_ADDR.
REQ-020 The status word SHALL be: bit0 empty, bit1 full, bit2 overflow, bits[15:8] occupancy count, and all other bits 0.
REQ-021 A write to OUT_ADDR SHALL push writeramdata[7:0] into the FIFO at the next clock edge, and the byte SHALL appear on out_data no earlier than the following cycle (1-cycle latency).
REQ-022 A write to STAT_ADDR with data bit0 = 1 SHALL clear the sticky overflow flag; other bits are ignored.
REQ-023 out_valid SHALL be 1 whenever the count is nonzero; a pop occurs on a clock edge where out_valid and out_ready are both 1.
REQ-024 out_data SHALL be the FIFO head and SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-025 A push while full without a simultaneous pop SHALL drop the byte, leave the FIFO contents and count unchanged, and set overflow.
REQ-026 A push while full with a simultaneous pop SHALL be accepted; the count stays at DEPTH.
REQ-027 A push while empty SHALL not bypass to the output: out_valid stays 0 that cycle, and the count becomes 1 next cycle.
REQ-028 A simultaneous push and pop with count between 1 and DEPTH-1 SHALL leave the count unchanged.
REQ-029 The read and write pointers SHALL wrap modulo DEPTH; the count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-030 If an overflow set and a clear occur in the same cycle, set SHALL win.

Reset
REQ-031 While reset = 1 at a clock edge, the pointers, count and overflow SHALL go to 0; out_valid then reads 0 and the status word reads 32'h0000_0001.
REQ-032 Reset mid-stream SHALL discard all buffered bytes; any push requested in the reset cycle SHALL be ignored.
REQ-033 The FIFO storage array SHALL not require reset; out_data is don't-care while out_valid = 0.

Structure
REQ-034 A shared package mmio_pkg SHALL hold the OUT_ADDR and STAT_ADDR default constants and the status bit-index constants (EMPTY_BIT, FULL_BIT, OVF_BIT, and the count field LSB/MSB).
REQ-035 The FIFO SHALL be one sub-module, byte_fifo (push, pop, din, dout, count, full, empty); decode, muxing and the overflow flag stay in mmio_stream_out.

Verification
REQ-036 Pass-through: store 32'hDEAD_BEEF to address 0x40, then load 0x40 → ram_we = 1 on the store only, ram_addr = 0x40, readramdata = ram_rdata; out_valid stays 0.
REQ-037 Latency/order: store bytes 0x11, 0x22, 0x33 to OUT_ADDR with out_ready = 0 → out_valid rises the cycle after the first store; status reads 32'h0000_0300; with out_ready = 1, the bytes exit as 0x11, 0x22, 0x33, then status reads 32'h0000_0001.
REQ-038 Full/overflow: 17 pushes with out_ready = 0 (DEPTH = 16) → status reads 32'h0000_1006 (full, overflow, count 16) and the 17th byte never appears; a STAT_ADDR write of 1 → status reads 32'h0000_1002.
REQ-039 Full with simultaneous push and pop: with the FIFO full, out_ready = 1, push 0xAA → count stays 16 and 0xAA exits last after 16 more pops; overflow stays 0.
REQ-040 Wrap-around: 40 push/pop pairs of incrementing bytes with random out_ready → output sequence equals the input sequence and no overflow is set.
REQ-041 Reset mid-stream: 5 bytes queued, then reset = 1 for one cycle together with a push → out_valid = 0 next cycle and status reads 32'h0000_0001.
